// File: rtl/disk_spin_ctrl_pkg.sv
// Shared types for the spinning-disk controller: FSM states and the
// position-to-segment table for one active-low 7-segment digit.
package disk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEL  = 2'd1,
    CRUISE = 2'd2,
    DECEL  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // {dp,g,f,e,d,c,b,a}, active-low; one outer segment lit per position.
  localparam logic [7:0] SEG_TABLE [0:5] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF};

  function automatic logic [7:0] pos_to_seg(input logic [2:0] pos);
    logic [7:0] seg;
    seg = SEG_OFF;
    if (pos < 3'd6) seg = SEG_TABLE[pos];
    return seg;
  endfunction

endpackage

// File: rtl/disk_spin_ctrl_if.sv
// Control/status bundle between a scheduler (master) and the disk controller (slave).
interface disk_spin_ctrl_if;
  // Start is a level request taken only while Busy is low (not queued);
  // Stop is a level request honoured only while accelerating or cruising;
  // Dir is captured together with an accepted Start; Busy is high for the
  // whole run and Done pulses for one cycle as Busy falls after deceleration.
  logic       Start;
  logic       Stop;
  logic       Dir;
  logic [7:0] SSeg;
  logic       Busy;
  logic       Done;

  modport master (output Start, Stop, Dir, input SSeg, Busy, Done);
  modport slave  (input Start, Stop, Dir, output SSeg, Busy, Done);
endinterface

// File: rtl/disk_spin_ctrl_step_timer.sv
// Step timer: counts each step period, owns the period register and flags
// steps and revolution-ending (wrapping) steps.
module disk_step_timer #(
  parameter int PERIOD_MAX  = 16,
  parameter int PERIOD_MIN  = 4,
  parameter int PERIOD_STEP = 4,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic          dec,
  input  logic          dir,
  input  logic          run,
  input  logic [2:0]    pos,
  output logic          step,
  output logic          rev_end,
  output logic [CW-1:0] period
);

  localparam logic [CW:0] MAX_X  = (CW+1)'(PERIOD_MAX);
  localparam logic [CW:0] MIN_X  = (CW+1)'(PERIOD_MIN);
  localparam logic [CW:0] STEP_X = (CW+1)'(PERIOD_STEP);

  logic [CW-1:0] cnt;
  logic [CW:0]   period_x;
  logic [CW:0]   up_x;
  logic [CW:0]   down_x;

  // One extra bit keeps the saturating add/subtract free of wrap-around.
  assign period_x = {1'b0, period};
  assign up_x     = (period_x + STEP_X >= MAX_X) ? MAX_X : period_x + STEP_X;
  assign down_x   = (period_x >= MIN_X + STEP_X) ? period_x - STEP_X : MIN_X;

  assign step    = run && (cnt == period - 1'b1);
  assign rev_end = step && (dir ? (pos == 3'd5) : (pos == 3'd0));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt    <= '0;
      period <= MAX_X[CW-1:0];
    end else begin
      if (run) cnt <= step ? '0 : cnt + 1'b1;
      if (dec)      period <= down_x[CW-1:0];
      else if (inc) period <= up_x[CW-1:0];
    end
  end

endmodule

// File: rtl/disk_spin_ctrl.sv
// Spinning-disk sequencer: accelerate, cruise, decelerate on one 7-segment
// digit, with Start/Stop requests and Busy/Done status.
module disk_spin_ctrl
  import disk_pkg::*;
#(
  parameter int PERIOD_MAX  = 16,
  parameter int PERIOD_MIN  = 4,
  parameter int PERIOD_STEP = 4,
  parameter int CRUISE_REVS = 2,
  parameter int CW          = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  disk_spin_ctrl_if.slave  bus,
  output state_t           fsm_state
);

  localparam logic [CW:0]   MIN_PLUS_STEP = (CW+1)'(PERIOD_MIN + PERIOD_STEP);
  localparam logic [CW-1:0] MAX_P         = CW'(PERIOD_MAX);
  localparam logic [CW-1:0] REVS_LAST     = CW'(CRUISE_REVS - 1);

  state_t        state_q, state_d;
  logic [2:0]    pos_q;
  logic [CW-1:0] revs_q, revs_d;
  logic          dir_q;
  logic          done_q, done_d;
  logic          load, inc, dec, run;
  logic          step, rev_end;
  logic [CW-1:0] period;

  assign run = (state_q != IDLE);

  disk_step_timer #(
    .PERIOD_MAX (PERIOD_MAX),
    .PERIOD_MIN (PERIOD_MIN),
    .PERIOD_STEP(PERIOD_STEP),
    .CW         (CW)
  ) u_timer (
    .clk    (Clk),
    .rst    (Reset),
    .load   (load),
    .inc    (inc),
    .dec    (dec),
    .dir    (dir_q),
    .run    (run),
    .pos    (pos_q),
    .step   (step),
    .rev_end(rev_end),
    .period (period)
  );

  always_comb begin
    state_d = state_q;
    revs_d  = revs_q;
    done_d  = 1'b0;
    load    = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = ACCEL;
          load    = 1'b1;
        end
      end
      ACCEL: begin
        if (rev_end) begin
          dec = 1'b1;
          if ({1'b0, period} <= MIN_PLUS_STEP) begin
            state_d = CRUISE;
            revs_d  = '0;
          end
        end
        // Stop overrides any transition taken at the same revolution boundary.
        if (bus.Stop) state_d = DECEL;
      end
      CRUISE: begin
        if (rev_end) begin
          revs_d = revs_q + 1'b1;
          if ((CRUISE_REVS != 0) && (revs_q == REVS_LAST)) state_d = DECEL;
        end
        if (bus.Stop) state_d = DECEL;
      end
      DECEL: begin
        if (rev_end) begin
          if (period == MAX_P) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      pos_q   <= 3'd0;
      revs_q  <= '0;
      dir_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      revs_q  <= revs_d;
      done_q  <= done_d;
      if (load) dir_q <= bus.Dir;
      if (step) begin
        if (dir_q) pos_q <= (pos_q == 3'd5) ? 3'd0 : pos_q + 3'd1;
        else       pos_q <= (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
      end
    end
  end

  assign bus.SSeg = pos_to_seg(pos_q);
  assign bus.Busy = run;
  assign bus.Done = done_q;
  assign fsm_state = state_q;

endmodule
